// File: rtl/wm_panel_if.sv
// Panel bus: raw board inputs and controller status in, controller commands
// and panel indicators out.
interface wm_panel_if;
   logic       power_btn, prog_btn, start_btn, door_sw, soap_sw;
   logic       lock_door, program_done, soap_warning;
   logic [7:0] timer_display;
   logic       power, start, doorclosed, soap, buzzer, req_fail;
   logic [2:0] program_selection;
   logic [7:0] display_value;

   modport master (
      output power_btn, prog_btn, start_btn, door_sw, soap_sw,
      output lock_door, program_done, soap_warning, timer_display,
      input  power, program_selection, start, doorclosed, soap,
      input  buzzer, req_fail, display_value
   );

   modport slave (
      input  power_btn, prog_btn, start_btn, door_sw, soap_sw,
      input  lock_door, program_done, soap_warning, timer_display,
      output power, program_selection, start, doorclosed, soap,
      output buzzer, req_fail, display_value
   );
endinterface

// File: rtl/wm_control_panel.sv
// Washing-machine front panel: synchronizes and debounces the raw buttons,
// runs the power/select/start/run/buzz sequence and drives the display.
module wm_control_panel #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REQ_TIMEOUT     = 16,
   parameter int BUZZ_CYCLES     = 6,
   parameter int BLINK_CYCLES    = 4,
   parameter int NUM_PROGRAMS    = 5
) (
   input  logic       clk,
   input  logic       rst,
   wm_panel_if.slave  bus
);
   localparam int NIN = 5;
   localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW  = $clog2(REQ_TIMEOUT + 1);
   localparam int BW  = $clog2(BUZZ_CYCLES + 1);
   localparam int KW  = $clog2(BLINK_CYCLES + 1);
   // input channel indices
   localparam int PWR = 0, PRG = 1, STR = 2, DOOR = 3, SOAP = 4;

   typedef enum logic [2:0] {S_OFF, S_READY, S_REQUEST, S_RUNNING, S_BUZZ} state_t;

   logic [NIN-1:0] raw, db;
   logic [2:0]     db_prev, press;

   assign raw = {bus.soap_sw, bus.door_sw, bus.start_btn, bus.prog_btn, bus.power_btn};

   for (genvar i = 0; i < NIN; i++) begin : g_in
      logic          s1, s2, dbr;
      logic [DW-1:0] cnt;
      // two-flop sync, then accept a new level only after it holds steadily
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            s1 <= 1'b0; s2 <= 1'b0; dbr <= 1'b0; cnt <= '0;
         end else begin
            s1 <= raw[i];
            s2 <= s1;
            if (s2 == dbr)
               cnt <= '0;
            else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
               dbr <= s2;
               cnt <= '0;
            end else
               cnt <= cnt + 1'b1;
         end
      assign db[i] = dbr;
   end

   // previous debounced level of the three push-buttons for edge detection
   always_ff @(posedge clk or posedge rst)
      if (rst) db_prev <= '0;
      else     db_prev <= db[2:0];

   assign press = db[2:0] & ~db_prev;

   state_t        state, state_n;
   logic          power_r, power_n, start_r, start_n, buzz_r, buzz_n, fail_r, fail_n;
   logic [2:0]    sel_r, sel_n;
   logic [TW-1:0] tmo, tmo_n;
   logic [BW-1:0] bcnt, bcnt_n;
   logic [KW-1:0] blink_cnt;
   logic          blink_flag;

   // state and registered command outputs
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= S_OFF; power_r <= 1'b0; start_r <= 1'b0; buzz_r <= 1'b0;
         fail_r <= 1'b0; sel_r <= '0; tmo <= '0; bcnt <= '0;
      end else begin
         state <= state_n; power_r <= power_n; start_r <= start_n; buzz_r <= buzz_n;
         fail_r <= fail_n; sel_r <= sel_n; tmo <= tmo_n; bcnt <= bcnt_n;
      end

   // next-state logic; a power press outside OFF overrides everything
   always_comb begin
      state_n = state;
      power_n = power_r;
      start_n = start_r;
      buzz_n  = buzz_r;
      fail_n  = 1'b0;
      sel_n   = sel_r;
      tmo_n   = tmo;
      bcnt_n  = bcnt;
      if (state != S_OFF && press[PWR]) begin
         state_n = S_OFF;
         power_n = 1'b0;
         start_n = 1'b0;
         buzz_n  = 1'b0;
         sel_n   = '0;
         tmo_n   = '0;
         bcnt_n  = '0;
      end else begin
         case (state)
            S_OFF:
               if (press[PWR]) begin
                  state_n = S_READY;
                  power_n = 1'b1;
                  sel_n   = '0;
               end
            S_READY:
               // a start refused for an open door does not mask a prog press
               if (press[STR] && db[DOOR]) begin
                  state_n = S_REQUEST;
                  start_n = 1'b1;
                  tmo_n   = '0;
               end else if (press[PRG])
                  sel_n = (sel_r == 3'(NUM_PROGRAMS - 1)) ? 3'd0 : sel_r + 3'd1;
            S_REQUEST:
               if (bus.lock_door) begin
                  state_n = S_RUNNING;
                  start_n = 1'b0;
                  tmo_n   = '0;
               end else if (!db[DOOR] || tmo == TW'(REQ_TIMEOUT - 1)) begin
                  state_n = S_READY;
                  start_n = 1'b0;
                  fail_n  = 1'b1;
                  tmo_n   = '0;
               end else
                  tmo_n = tmo + 1'b1;
            S_RUNNING:
               if (bus.program_done) begin
                  state_n = S_BUZZ;
                  buzz_n  = 1'b1;
                  bcnt_n  = '0;
               end
            S_BUZZ:
               if (bcnt == BW'(BUZZ_CYCLES - 1)) begin
                  state_n = S_READY;
                  buzz_n  = 1'b0;
                  bcnt_n  = '0;
               end else
                  bcnt_n = bcnt + 1'b1;
            default: state_n = S_OFF;
         endcase
      end
   end

   // blink phase while running with a soap warning; flag=0 shows FF first
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         blink_cnt <= '0; blink_flag <= 1'b0;
      end else if (state != S_RUNNING || !bus.soap_warning) begin
         blink_cnt <= '0; blink_flag <= 1'b0;
      end else if (blink_cnt == KW'(BLINK_CYCLES - 1)) begin
         blink_cnt <= '0; blink_flag <= ~blink_flag;
      end else
         blink_cnt <= blink_cnt + 1'b1;

   // display mux
   always_comb begin
      bus.display_value = 8'h00;
      case (state)
         S_READY, S_REQUEST: bus.display_value = {5'b0, sel_r};
         S_RUNNING: bus.display_value = (bus.soap_warning && !blink_flag) ? 8'hFF
                                                                          : bus.timer_display;
         default: bus.display_value = 8'h00;
      endcase
   end

   assign bus.power             = power_r;
   assign bus.start             = start_r;
   assign bus.buzzer            = buzz_r;
   assign bus.req_fail          = fail_r;
   assign bus.program_selection = sel_r;
   assign bus.doorclosed        = db[DOOR];
   assign bus.soap              = db[SOAP];
endmodule
